game_flow_ctrl: RTL and testbench

//  Top-level game sequencer for Blobby Volley. Owns the flow menu -> serve -> rally -> point pause
//  -> game over -> menu. It replaces ad-hoc flag logic in the menu overlay with one registered FSM.

---
 rtl/game_flow_ctrl_pkg.sv | 21 ++
 rtl/game_flow_ctrl_rise_detect.sv | 22 ++
 rtl/game_flow_ctrl.sv | 159 +++++++++++++++
 tb/tb_game_flow_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared game-flow definitions: state encodings, score width and the saturating score helper.
// Also imported by the menu overlay and the score renderer.
package game_flow_ctrl_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [2:0] {
        MENU        = 3'd0,
        START       = 3'd1,
        SERVE       = 3'd2,
        RALLY       = 3'd3,
        POINT_PAUSE = 3'd4,
        GAME_OVER   = 3'd5
    } state_t;

    // Scores stop at all-ones rather than wrapping back to zero.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/game_flow_ctrl_rise_detect.sv
// One-bit rising-edge detector: previous-cycle register, pulse while the input is newly high.
module game_flow_ctrl_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_r;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= d;
        end
    end

    assign rise = d & ~prev_r;

endmodule

// File: rtl/game_flow_ctrl.sv
// Blobby Volley game sequencer: menu -> serve -> rally -> point pause -> game over -> menu,
// with registered enables, score registers and the game_reset pulse to the datapath.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int BTN_X        = 340,
    parameter int BTN_Y        = 330,
    parameter int BTN_W        = 390,
    parameter int BTN_H        = 50,
    parameter int WIN_SCORE    = 15,
    parameter int SERVE_FRAMES = 30,
    parameter int PAUSE_FRAMES = 90
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               left,
    input  logic [11:0]        xpos,
    input  logic [11:0]        ypos,
    input  logic               vblnk,
    input  logic               point_evt,
    input  logic               point_side,
    output logic               enable_menu,
    output logic               enable_game,
    output logic               mousecontrol,
    output logic               game_reset,
    output logic               flag_point,
    output logic               endgame,
    output logic               serve_side,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2
);

    localparam logic [11:0]        X_LO       = 12'(BTN_X);
    localparam logic [11:0]        X_HI       = 12'(BTN_X + BTN_W);
    localparam logic [11:0]        Y_LO       = 12'(BTN_Y);
    localparam logic [11:0]        Y_HI       = 12'(BTN_Y + BTN_H);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]         PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

    state_t             state_r, state_nxt_s;
    logic [7:0]         frame_cnt_r, frame_nxt_s;
    logic [SCORE_W-1:0] p1_nxt_s, p2_nxt_s, p1_inc_s, p2_inc_s;
    logic               serve_nxt_s;
    logic               left_rise_s, tick_s, in_box_s, click_s;

    game_flow_ctrl_rise_detect u_rise_left (
        .clk  (clk),
        .rst  (rst),
        .d    (left),
        .rise (left_rise_s)
    );

    game_flow_ctrl_rise_detect u_rise_vblnk (
        .clk  (clk),
        .rst  (rst),
        .d    (vblnk),
        .rise (tick_s)
    );

    assign in_box_s = (xpos >= X_LO) && (xpos <= X_HI) && (ypos >= Y_LO) && (ypos <= Y_HI);
    assign click_s  = left_rise_s & in_box_s;
    assign p1_inc_s = score_inc(score_p1);
    assign p2_inc_s = score_inc(score_p2);

    // Next state, frame counter and score/serve updates; scores clear on the way into START.
    always_comb begin
        state_nxt_s = state_r;
        p1_nxt_s    = score_p1;
        p2_nxt_s    = score_p2;
        serve_nxt_s = serve_side;
        case (state_r)
            MENU, GAME_OVER: begin
                if (click_s) begin
                    state_nxt_s = START;
                    p1_nxt_s    = '0;
                    p2_nxt_s    = '0;
                    serve_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            START: begin
                state_nxt_s = SERVE;
            end
            SERVE: begin
                if (tick_s && (frame_cnt_r == SERVE_LAST)) begin
                    state_nxt_s = RALLY;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            RALLY: begin
                if (point_evt) begin
                    serve_nxt_s = point_side;
                    if (point_side) begin
                        p2_nxt_s    = p2_inc_s;
                        state_nxt_s = (p2_inc_s == WIN_VAL) ? GAME_OVER : POINT_PAUSE;
                    end else begin
                        p1_nxt_s    = p1_inc_s;
                        state_nxt_s = (p1_inc_s == WIN_VAL) ? GAME_OVER : POINT_PAUSE;
                    end
                end else begin
                    state_nxt_s = RALLY;
                end
            end
            POINT_PAUSE: begin
                if (tick_s && (frame_cnt_r == PAUSE_LAST)) begin
                    state_nxt_s = SERVE;
                end else begin
                    state_nxt_s = POINT_PAUSE;
                end
            end
            default: begin
                state_nxt_s = MENU;
            end
        endcase

        if (state_nxt_s != state_r) begin
            frame_nxt_s = 8'd0;
        end else if (tick_s && ((state_r == SERVE) || (state_r == POINT_PAUSE))) begin
            frame_nxt_s = frame_cnt_r + 8'd1;
        end else begin
            frame_nxt_s = frame_cnt_r;
        end
    end

    // State, counters and outputs; outputs are decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= MENU;
            frame_cnt_r  <= 8'd0;
            score_p1     <= '0;
            score_p2     <= '0;
            serve_side   <= 1'b0;
            enable_menu  <= 1'b1;
            enable_game  <= 1'b0;
            mousecontrol <= 1'b0;
            game_reset   <= 1'b0;
            flag_point   <= 1'b0;
            endgame      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            frame_cnt_r  <= frame_nxt_s;
            score_p1     <= p1_nxt_s;
            score_p2     <= p2_nxt_s;
            serve_side   <= serve_nxt_s;
            enable_menu  <= (state_nxt_s == MENU) || (state_nxt_s == GAME_OVER);
            enable_game  <= (state_nxt_s == SERVE) || (state_nxt_s == RALLY);
            mousecontrol <= (state_nxt_s == SERVE) || (state_nxt_s == RALLY) ||
                            (state_nxt_s == POINT_PAUSE);
            game_reset   <= (state_nxt_s == START) ||
                            ((state_r == POINT_PAUSE) && (state_nxt_s == SERVE));
            flag_point   <= (state_nxt_s == POINT_PAUSE);
            endgame      <= (state_nxt_s == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl (WIN_SCORE=3): menu clicks, serve/pause timing, scoring, reset.
module tb_game_flow_ctrl;

    logic        clk, rst, left, vblnk, point_evt, point_side;
    logic [11:0] xpos, ypos;
    logic        enable_menu, enable_game, mousecontrol, game_reset, flag_point, endgame, serve_side;
    logic [3:0]  score_p1, score_p2;
    int          n_cmp, n_bad;

    game_flow_ctrl #(
        .WIN_SCORE    (3),
        .SERVE_FRAMES (30),
        .PAUSE_FRAMES (90)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .left         (left),
        .xpos         (xpos),
        .ypos         (ypos),
        .vblnk        (vblnk),
        .point_evt    (point_evt),
        .point_side   (point_side),
        .enable_menu  (enable_menu),
        .enable_game  (enable_game),
        .mousecontrol (mousecontrol),
        .game_reset   (game_reset),
        .flag_point   (flag_point),
        .endgame      (endgame),
        .serve_side   (serve_side),
        .score_p1     (score_p1),
        .score_p2     (score_p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [11:0] x, input logic [11:0] y);
        xpos = x;
        ypos = y;
        left = 1'b1;
        cyc(1);
    endtask

    task automatic release_btn();
        left = 1'b0;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            vblnk = 1'b1;
            cyc(1);
            vblnk = 1'b0;
            cyc(1);
        end
    endtask

    task automatic point(input logic side);
        point_evt  = 1'b1;
        point_side = side;
        cyc(1);
        point_evt  = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; left = 1'b0; vblnk = 1'b0; point_evt = 1'b0; point_side = 1'b0;
        xpos = 12'd0; ypos = 12'd0;

        // 1: reset state and a plain click
        cyc(5);
        rst = 1'b0;
        chk("rst_menu", {7'd0, enable_menu}, 8'd1);
        chk("rst_outs", {2'd0, enable_game, mousecontrol, game_reset, flag_point, endgame, serve_side}, 8'd0);
        chk("rst_scores", {score_p1, score_p2}, 8'd0);
        press(12'd500, 12'd350);
        chk("start_gr", {7'd0, game_reset}, 8'd1);
        chk("start_menu", {7'd0, enable_menu}, 8'd0);
        release_btn();
        chk("serve_gr", {7'd0, game_reset}, 8'd0);
        chk("serve_en", {6'd0, enable_game, mousecontrol}, 8'd3);

        // 3: serve timing, point ignored while serving
        ticks(29);
        point(1'b0);
        chk("serve_pt_ign", {score_p1, score_p2}, 8'd0);
        chk("serve_no_flag", {7'd0, flag_point}, 8'd0);
        vblnk = 1'b1;
        cyc(1);
        vblnk = 1'b0;
        point(1'b1);
        // 4: point for P2 on the first RALLY cycle
        chk("p2_score", {score_p1, score_p2}, 8'h01);
        chk("p2_serve", {7'd0, serve_side}, 8'd1);
        chk("pause_outs", {5'd0, flag_point, mousecontrol, enable_game}, 8'b110);
        point(1'b0);
        chk("pause_pt_ign", {score_p1, score_p2}, 8'h01);
        ticks(89);
        chk("pause_held", {6'd0, flag_point, game_reset}, 8'b10);
        vblnk = 1'b1;
        cyc(1);
        chk("pause_end", {5'd0, game_reset, flag_point, enable_game}, 8'b101);
        vblnk = 1'b0;
        cyc(1);
        chk("pause_gr_1cyc", {7'd0, game_reset}, 8'd0);

        // 5: three P1 points reach WIN_SCORE
        for (int k = 0; k < 3; k++) begin
            ticks(30);
            point(1'b0);
            if (k < 2) ticks(90);
        end
        chk("go_outs", {4'd0, endgame, enable_menu, mousecontrol, flag_point}, 8'b1100);
        chk("go_scores", {score_p1, score_p2}, 8'h31);
        chk("go_serve", {7'd0, serve_side}, 8'd0);
        ticks(3);
        point(1'b1);
        chk("go_held", {score_p1, score_p2}, 8'h31);
        press(12'd600, 12'd360);
        chk("go_restart", {score_p1, score_p2}, 8'h00);
        chk("go_restart_gr", {6'd0, game_reset, endgame}, 8'b10);
        release_btn();

        // 6: reset in RALLY with score_p1=2
        for (int k = 0; k < 2; k++) begin
            ticks(30);
            point(1'b0);
            ticks(90);
        end
        ticks(30);
        chk("pre_rst_p1", {score_p1, score_p2}, 8'h20);
        rst = 1'b1;
        cyc(1);
        chk("midrst_outs", {5'd0, enable_menu, enable_game, game_reset}, 8'b100);
        chk("midrst_scores", {score_p1, score_p2}, 8'h00);
        rst = 1'b0;
        cyc(1);
        chk("midrst_no_gr", {7'd0, game_reset}, 8'd0);

        // 2: button box boundaries and drag-in
        press(12'd339, 12'd350);
        chk("left_out", {6'd0, enable_menu, game_reset}, 8'b10);
        release_btn();
        press(12'd731, 12'd350);
        chk("right_out", {6'd0, enable_menu, game_reset}, 8'b10);
        release_btn();
        press(12'd730, 12'd381);
        chk("below_out", {6'd0, enable_menu, game_reset}, 8'b10);
        release_btn();
        press(12'd300, 12'd350);
        xpos = 12'd500;
        cyc(2);
        chk("drag_in", {6'd0, enable_menu, game_reset}, 8'b10);
        release_btn();
        press(12'd340, 12'd330);
        chk("edge_tl", {6'd0, enable_menu, game_reset}, 8'b01);
        release_btn();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        press(12'd730, 12'd380);
        chk("edge_br", {6'd0, enable_menu, game_reset}, 8'b01);
        release_btn();
        chk("edge_br_serve", {6'd0, enable_game, game_reset}, 8'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
